// File: rtl/ttl_arb_pkg.sv
// ttl_arb_pkg: shared state encoding and width helper for the bus arbiter.
// Contents: state_t (ST_IDLE/ST_GRANT/ST_TURN) and wmin1(), which returns
// max(1, $clog2(n)) and sizes the Owner, pointer and hold-counter fields.
package ttl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    function automatic int wmin1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ttl_bus_arbiter_if.sv
// ttl_bus_arbiter_if: request/grant bundle between requesters and the arbiter.
// Signals: Req (requests), Gnt (one-hot grant), OE_bar (active-low driver
// enables), Owner (index of the current owner), Busy, and Preempt.
// Modports: master = arbiter side, slave = requester side.
interface ttl_bus_arbiter_if
    import ttl_arb_pkg::*;
#(
    parameter int BLOCKS = 4
);
    localparam int OW = wmin1(BLOCKS);

    logic [BLOCKS-1:0] Req;
    logic [BLOCKS-1:0] Gnt;
    logic [BLOCKS-1:0] OE_bar;
    logic [OW-1:0]     Owner;
    logic              Busy;
    logic              Preempt;

    modport master (input Req, output Gnt, OE_bar, Owner, Busy, Preempt);
    modport slave  (output Req, input Gnt, OE_bar, Owner, Busy, Preempt);

endinterface

// File: rtl/ttl_rr_pick.sv
// ttl_rr_pick: combinational round-robin winner search.
// Ports: req_i (request vector), ptr_i (search start index),
// any_o (some request present), win_o (first set bit at or above ptr_i, wrapping).
module ttl_rr_pick
    import ttl_arb_pkg::*;
#(
    parameter int BLOCKS = 4,
    localparam int PW = wmin1(BLOCKS)
) (
    input  logic [BLOCKS-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    output logic              any_o,
    output logic [PW-1:0]     win_o
);

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        win_o = '0;
        for (int i = BLOCKS - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % BLOCKS]) win_o = PW'((int'(ptr_i) + i) % BLOCKS);
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/ttl_bus_arbiter.sv
// ttl_bus_arbiter: round-robin owner selection for a shared tristate bus.
// Ports: Clk (rising edge), Clear (async active-high reset),
// bus (master modport: Req in; Gnt, OE_bar, Owner, Busy, Preempt out).
// Each tenure is followed by one all-zero turnaround cycle. When MAX_HOLD > 0,
// a tenure is cut off after MAX_HOLD grant cycles.
module ttl_bus_arbiter
    import ttl_arb_pkg::*;
#(
    parameter int BLOCKS     = 4,
    parameter int MAX_HOLD   = 0,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input logic               Clk,
    input logic               Clear,
    ttl_bus_arbiter_if.master bus
);
    localparam int PW = wmin1(BLOCKS);
    localparam int CW = wmin1(MAX_HOLD + 1);

    // This RTL registers every output and drives it at the clock edge.
    // Output delays belong to the chip-level timing model, so DELAY_RISE
    // and DELAY_FALL are only range-checked here.
    if (BLOCKS < 2 || BLOCKS > 8 || MAX_HOLD < 0 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
        $error("ttl_bus_arbiter: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, owner_q, owner_d, win;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BLOCKS-1:0] gnt_q, gnt_d;
    logic              pre_q, pre_d, any, limit, own_req;

    ttl_rr_pick #(.BLOCKS(BLOCKS)) u_pick (
        .req_i (bus.Req),
        .ptr_i (ptr_q),
        .any_o (any),
        .win_o (win)
    );

    assign own_req = bus.Req[owner_q];
    // cnt_q counts completed grant cycles, so this tests the count after the current one.
    assign limit   = (MAX_HOLD > 0) && (int'(cnt_q) + 1 >= MAX_HOLD);

    // IDLE and TURN both arbitrate on the current Req. The only difference
    // is the state they were entered from.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        pre_d   = 1'b0;
        if (state_q == ST_GRANT) begin
            if (!own_req || limit) begin
                state_d = ST_TURN;
                gnt_d   = '0;
                owner_d = '0;
                pre_d   = own_req;
            end else begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end
        end else if (any) begin
            state_d = ST_GRANT;
            gnt_d   = BLOCKS'(1) << win;
            owner_d = win;
            cnt_d   = '0;
            ptr_d   = (int'(win) == BLOCKS - 1) ? '0 : win + 1'b1;
        end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            owner_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.Gnt     = gnt_q;
    assign bus.OE_bar  = ~gnt_q;
    assign bus.Owner   = owner_q;
    assign bus.Busy    = |gnt_q;
    assign bus.Preempt = pre_q;

endmodule

// File: tb/tb_ttl_bus_arbiter.sv
// tb_ttl_bus_arbiter: self-checking bench for ttl_bus_arbiter. It runs two
// instances, one with no hold limit and one with MAX_HOLD=3.
module tb_ttl_bus_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       pre;
    } vec_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    // The reference model is kept per instance: index 0 has no limit, index 1 has MAX_HOLD=3.
    int   m_own[2];
    int   m_ptr[2];
    int   m_hold[2];
    logic m_pre[2];

    logic [3:0] pv0, pv3;
    vec_t tv[26];
    vec_t hv[9];

    always #5 clk = ~clk;

    ttl_bus_arbiter_if #(.BLOCKS(4)) if0 ();
    ttl_bus_arbiter_if #(.BLOCKS(4)) if3 ();

    ttl_bus_arbiter #(.BLOCKS(4), .MAX_HOLD(0)) dut0 (.Clk(clk), .Clear(clear), .bus(if0));
    ttl_bus_arbiter #(.BLOCKS(4), .MAX_HOLD(3)) dut3 (.Clk(clk), .Clear(clear), .bus(if3));

    function automatic int lim(input int m);
        return (m == 1) ? 3 : 0;
    endfunction

    function automatic logic [11:0] pack(input logic [3:0] g, input logic [1:0] o, input logic p);
        return {g, ~g, o, |g, p};
    endfunction

    function automatic logic [11:0] obs0();
        return {if0.Gnt, if0.OE_bar, if0.Owner, if0.Busy, if0.Preempt};
    endfunction

    function automatic logic [11:0] obs3();
        return {if3.Gnt, if3.OE_bar, if3.Owner, if3.Busy, if3.Preempt};
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [11:0] expm(input int m);
        logic [3:0] g;
        g = (m_own[m] >= 0) ? 4'(1 << m_own[m]) : 4'b0000;
        return pack(g, (m_own[m] >= 0) ? 2'(m_own[m]) : 2'd0, m_pre[m]);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_own[m]  = -1;
            m_ptr[m]  = 0;
            m_hold[m] = 0;
            m_pre[m]  = 1'b0;
        end
    endtask

    // One clock edge of the model. The gap cycle after a tenure comes from
    // leaving the owner empty for one edge. m_hold counts grant cycles so far.
    task automatic step(input int m, input logic [3:0] r);
        int w;
        m_pre[m] = 1'b0;
        if (m_own[m] >= 0) begin
            if (!r[m_own[m]]) m_own[m] = -1;
            else if (lim(m) > 0 && m_hold[m] >= lim(m)) begin
                m_own[m] = -1;
                m_pre[m] = 1'b1;
            end else m_hold[m]++;
        end else begin
            w = pick(r, m_ptr[m]);
            if (w >= 0) begin
                m_own[m]  = w;
                m_hold[m] = 1;
                m_ptr[m]  = (w + 1) % 4;
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [11:0] a, input logic [11:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got gnt=%b oe_bar=%b owner=%0d busy=%b preempt=%b, expected gnt=%b oe_bar=%b owner=%0d busy=%b preempt=%b",
                     nm, $time, a[11:8], a[7:4], a[3:2], a[1], a[0], e[11:8], e[7:4], e[3:2], e[1], e[0]);
        end
    endtask

    task automatic inv(input string nm, input logic [11:0] a, inout logic [3:0] prev);
        logic [3:0] g;
        logic ok;
        g  = a[11:8];
        ok = $onehot0(g) && (a[7:4] === ~g) && (a[1] === |g)
             && ((g == 4'b0000) ? (a[3:2] == 2'd0) : (g == 4'(1 << a[3:2])))
             && !(prev != 4'b0000 && g != 4'b0000 && prev != g);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s @%0t: gnt=%b oe_bar=%b owner=%0d busy=%b prev_gnt=%b break a bus invariant",
                     nm, $time, g, a[7:4], a[3:2], a[1], prev);
        end
        prev = g;
    endtask

    // Drive the requests (and release Clear) at the negedge, step the model at
    // the posedge, and compare both instances just after the edge.
    task automatic cyc(input logic [3:0] r0, input logic [3:0] r3);
        @(negedge clk);
        clear   = 1'b0;
        if0.Req = r0;
        if3.Req = r3;
        @(posedge clk);
        step(0, r0);
        step(1, r3);
        #1;
        cmp("model_nolimit", obs0(), expm(0));
        cmp("model_hold3", obs3(), expm(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        tv = '{
            '{4'b0100, 4'b0100, 2'd2, 1'b0}, '{4'b0100, 4'b0100, 2'd2, 1'b0},
            '{4'b0000, 4'b0000, 2'd0, 1'b0}, '{4'b0000, 4'b0000, 2'd0, 1'b0},
            '{4'b0101, 4'b0001, 2'd0, 1'b0}, '{4'b0000, 4'b0000, 2'd0, 1'b0},
            '{4'b0101, 4'b0100, 2'd2, 1'b0}, '{4'b0000, 4'b0000, 2'd0, 1'b0},
            '{4'b1000, 4'b1000, 2'd3, 1'b0}, '{4'b0000, 4'b0000, 2'd0, 1'b0},
            '{4'b0000, 4'b0000, 2'd0, 1'b0}, '{4'b1111, 4'b0001, 2'd0, 1'b0},
            '{4'b1111, 4'b0001, 2'd0, 1'b0}, '{4'b1110, 4'b0000, 2'd0, 1'b0},
            '{4'b1111, 4'b0010, 2'd1, 1'b0}, '{4'b1111, 4'b0010, 2'd1, 1'b0},
            '{4'b1101, 4'b0000, 2'd0, 1'b0}, '{4'b1111, 4'b0100, 2'd2, 1'b0},
            '{4'b1111, 4'b0100, 2'd2, 1'b0}, '{4'b1011, 4'b0000, 2'd0, 1'b0},
            '{4'b1111, 4'b1000, 2'd3, 1'b0}, '{4'b1111, 4'b1000, 2'd3, 1'b0},
            '{4'b0111, 4'b0000, 2'd0, 1'b0}, '{4'b1111, 4'b0001, 2'd0, 1'b0},
            '{4'b0000, 4'b0000, 2'd0, 1'b0}, '{4'b0000, 4'b0000, 2'd0, 1'b0}
        };
        hv = '{
            '{4'b0011, 4'b0001, 2'd0, 1'b0}, '{4'b0011, 4'b0001, 2'd0, 1'b0},
            '{4'b0011, 4'b0001, 2'd0, 1'b0}, '{4'b0011, 4'b0000, 2'd0, 1'b1},
            '{4'b0011, 4'b0010, 2'd1, 1'b0}, '{4'b0011, 4'b0010, 2'd1, 1'b0},
            '{4'b0011, 4'b0010, 2'd1, 1'b0}, '{4'b0011, 4'b0000, 2'd0, 1'b1},
            '{4'b0011, 4'b0001, 2'd0, 1'b0}
        };
        if0.Req = 4'b0000;
        if3.Req = 4'b0000;
        pv0 = 4'b0000;
        pv3 = 4'b0000;
        #1 clear = 1'b1;
        model_reset();
        #1;
        cmp("reset_nolimit", obs0(), pack(4'b0000, 2'd0, 1'b0));
        cmp("reset_hold3", obs3(), pack(4'b0000, 2'd0, 1'b0));

        // Single requester, wrap and skip, then rotation on the unlimited instance.
        for (int i = 0; i < 26; i++) begin
            cyc(tv[i].req, tv[i].req);
            cmp($sformatf("table_row%0d", i), obs0(), pack(tv[i].gnt, tv[i].own, tv[i].pre));
        end

        // Assert Clear asynchronously in the middle of a tenure.
        cyc(4'b0010, 4'b0010);
        #1 clear = 1'b1;
        model_reset();
        #1;
        cmp("async_clear_nolimit", obs0(), pack(4'b0000, 2'd0, 1'b0));
        cmp("async_clear_hold3", obs3(), pack(4'b0000, 2'd0, 1'b0));

        // Release Clear, then check hold-limit preemption alternating between requesters 0 and 1.
        for (int i = 0; i < 9; i++) begin
            cyc(4'b0010, hv[i].req);
            cmp($sformatf("hold_nolimit%0d", i), obs0(), pack(4'b0010, 2'd1, 1'b0));
            cmp($sformatf("hold_limit%0d", i), obs3(), pack(hv[i].gnt, hv[i].own, hv[i].pre));
        end

        // Random requests, biased high so tenures last several cycles, with an occasional async Clear.
        for (int i = 0; i < 4000; i++) begin
            cyc(4'($urandom) | 4'($urandom), 4'($urandom) | 4'($urandom));
            inv("invariant_nolimit", obs0(), pv0);
            inv("invariant_hold3", obs3(), pv3);
            if ($urandom_range(0, 399) == 0) begin
                #1 clear = 1'b1;
                model_reset();
                #1;
                cmp("rand_clear_nolimit", obs0(), pack(4'b0000, 2'd0, 1'b0));
                cmp("rand_clear_hold3", obs3(), pack(4'b0000, 2'd0, 1'b0));
                pv0 = 4'b0000;
                pv3 = 4'b0000;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
